// File: rtl/axi_burst_read_master_if.sv
// rtl/axi_burst_read_master_if.sv - AXI4 read address/data channel bundle
// Purpose : carries the AR and R channels between the burst read master and a slave.
// Signals : ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M/ARVALID_M  master -> slave
//           ARREADY_M                                             slave  -> master
//           RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M                slave  -> master
//           RREADY_M                                              master -> slave
// Modports: master (burst read master side), slave (memory side).
interface axi_burst_read_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [3:0]        ARID_M;
   logic [ADDR_W-1:0] ARADDR_M;
   logic [3:0]        ARLEN_M;
   logic [2:0]        ARSIZE_M;
   logic [1:0]        ARBURST_M;
   logic              ARVALID_M;
   logic              ARREADY_M;
   logic [3:0]        RID_M;
   logic [DATA_W-1:0] RDATA_M;
   logic [1:0]        RRESP_M;
   logic              RLAST_M;
   logic              RVALID_M;
   logic              RREADY_M;

   modport master (
      output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
      input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
   );

   modport slave (
      input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
      output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
   );
endinterface

// File: rtl/axi_burst_read_master.sv
// rtl/axi_burst_read_master.sv - single-burst AXI4 read master assembling one cache line
// Purpose : accepts a refill request, issues one INCR read burst, packs the returned
//           beats into a line and hands the line to a consumer.
// Ports   : clk, rst (async active-low)
//           req_valid/req_ready/req_addr/req_len       refill request (len = beats-1)
//           line_valid/line_ready/line_data/line_err   assembled line, beat k at [k*DATA_W +: DATA_W]
//           axi (master modport)                       AR and R channels
// Option  : define AXI_RRESP_CHECK_EN to enable line_err (error response, early RLAST,
//           beats past the requested length); otherwise line_err is tied low.
module axi_burst_read_master #(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter int         MAX_BEATS = 4,
   parameter logic [3:0] ID_VAL    = 4'd0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [3:0]                  req_len,
   output logic                        line_valid,
   input  logic                        line_ready,
   output logic [MAX_BEATS*DATA_W-1:0] line_data,
   output logic                        line_err,
   axi_burst_read_master_if.master     axi
);
   localparam int                BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(MAX_BEATS - 1);
   localparam logic [3:0]        LEN_MAX    = 4'(MAX_BEATS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
   localparam logic [2:0]        SIZE_VAL   = 3'($clog2(DATA_W / 8));

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        len_q;
   logic [BEAT_W-1:0] beat_cnt;
   // Set once the last slot has been written; later beats are drained but dropped.
   logic              beat_ovf;
   logic              arvalid_q;
   logic              rready_q;
   logic              beat_hs;
   logic [3:0]        len_clamped;

   assign len_clamped = (req_len > LEN_MAX) ? LEN_MAX : req_len;
   assign beat_hs     = rready_q && axi.RVALID_M;

   // AR payload comes straight from the request latches, so it cannot move while ARVALID waits.
   assign axi.ARID_M    = ID_VAL;
   assign axi.ARADDR_M  = addr_q;
   assign axi.ARLEN_M   = len_q;
   assign axi.ARSIZE_M  = SIZE_VAL;
   assign axi.ARBURST_M = 2'b01;
   assign axi.ARVALID_M = arvalid_q;
   assign axi.RREADY_M  = rready_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         line_valid <= 1'b0;
         line_data  <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt   <= '0;
         beat_ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q    <= req_addr & ~ALIGN_MASK;
                  len_q     <= len_clamped;
                  beat_cnt  <= '0;
                  beat_ovf  <= 1'b0;
                  req_ready <= 1'b0;
                  arvalid_q <= 1'b1;
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (axi.ARREADY_M) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_hs) begin
                  if (!beat_ovf) begin
                     line_data[beat_cnt * DATA_W +: DATA_W] <= axi.RDATA_M;
                  end
                  if (beat_cnt == BEAT_LAST) begin
                     beat_ovf <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
                  // RLAST alone ends the burst, whatever the beat count says.
                  if (axi.RLAST_M) begin
                     rready_q   <= 1'b0;
                     line_valid <= 1'b1;
                     state      <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (line_ready) begin
                  line_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef AXI_RRESP_CHECK_EN
   logic [3:0] beat_idx;
   logic       beat_early;
   logic       beat_late;
   logic       err_q;

   assign beat_idx   = 4'(beat_cnt);
   // RLAST on a beat before index len, or any beat with index beyond len.
   assign beat_early = axi.RLAST_M && !beat_ovf && (beat_idx < len_q);
   assign beat_late  = beat_ovf || (beat_idx > len_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state == S_IDLE && req_valid) begin
         err_q <= 1'b0;
      end else if (beat_hs && (axi.RRESP_M[1] || beat_early || beat_late)) begin
         err_q <= 1'b1;
      end
   end

   assign line_err = err_q;
`else
   assign line_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_burst_read_master.sv
// tb/tb_axi_burst_read_master.sv - randomized self-checking bench for axi_burst_read_master
module tb_axi_burst_read_master;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 4;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        req_valid;
   logic                        req_ready;
   logic [ADDR_W-1:0]           req_addr;
   logic [3:0]                  req_len;
   logic                        line_valid;
   logic                        line_ready;
   logic [MAX_BEATS*DATA_W-1:0] line_data;
   logic                        line_err;

   always #5 clk = ~clk;

   axi_burst_read_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

   axi_burst_read_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .ID_VAL(4'd0)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data), .line_err(line_err),
      .axi(axi)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model state
   logic [DATA_W-1:0]           model_line [MAX_BEATS];
   logic [DATA_W-1:0]           beat_data  [16];
   logic [MAX_BEATS*DATA_W-1:0] exp_line;
   logic                        exp_err;
   logic [ADDR_W-1:0]           exp_araddr;
   logic [3:0]                  exp_arlen;

   // observations of the last burst
   logic [ADDR_W-1:0]           obs_araddr;
   logic [3:0]                  obs_arlen, obs_arid;
   logic [2:0]                  obs_arsize;
   logic [1:0]                  obs_arburst;
   int                          obs_ar_hs, obs_lat;
   logic                        obs_ar_unstable, obs_rready_drop, obs_hold_unstable, obs_timeout;
   logic                        obs_err, obs_rr_before, obs_rr_after, obs_lv_after;
   logic [MAX_BEATS*DATA_W-1:0] obs_line;

   task automatic clear_model();
      for (int k = 0; k < MAX_BEATS; k++) model_line[k] = '0;
   endtask

   // Expected outcome of one burst: aligned address, clamped length, slots filled in
   // arrival order up to the line size, error whenever beat count != length or a beat errs.
   task automatic model_burst(input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                              input int nbeats, input int err_beat);
      int clen;
      clen       = (int'(len) > MAX_BEATS - 1) ? MAX_BEATS - 1 : int'(len);
      exp_araddr = addr - (addr % (DATA_W / 8));
      exp_arlen  = 4'(clen);
      for (int k = 0; k < nbeats && k < MAX_BEATS; k++) model_line[k] = beat_data[k];
      for (int k = 0; k < MAX_BEATS; k++) exp_line[k*DATA_W +: DATA_W] = model_line[k];
`ifdef AXI_RRESP_CHECK_EN
      exp_err = (nbeats != clen + 1) || (err_beat >= 0 && err_beat < nbeats);
`else
      exp_err = 1'b0;
`endif
   endtask

   // Drives one request and plays the slave; all driving and sampling on negedge.
   task automatic do_burst(input logic [ADDR_W-1:0] addr, input logic [3:0] len, input int nbeats,
                           input int err_beat, input int ar_wait, input bit r_gap,
                           input int ready_hold, input bit noise);
      int ar_waited = 0;
      int beat      = 0;
      int edges     = 0;
      bit give      = 1'b1;
      bit ar_seen   = 1'b0;
      bit in_data   = 1'b0;
      bit done      = 1'b0;
      for (int k = 0; k < 16; k++) beat_data[k] = $urandom;
      model_burst(addr, len, nbeats, err_beat);
      obs_ar_hs = 0; obs_lat = 0; obs_ar_unstable = 0; obs_rready_drop = 0;
      obs_hold_unstable = 0; obs_timeout = 0; obs_araddr = '0; obs_arlen = '0;
      obs_arid = '0; obs_arsize = '0; obs_arburst = '0;
      @(negedge clk);
      obs_rr_before = req_ready;
      req_valid = 1'b1; req_addr = addr; req_len = len;
      @(posedge clk); edges = 1;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         req_valid = noise; req_addr = $urandom; req_len = 4'($urandom);
         if (line_valid) begin done = 1'b1; break; end
         if (axi.ARVALID_M) begin
            if (!ar_seen) begin
               ar_seen = 1'b1;
               obs_araddr = axi.ARADDR_M; obs_arlen = axi.ARLEN_M; obs_arsize = axi.ARSIZE_M;
               obs_arburst = axi.ARBURST_M; obs_arid = axi.ARID_M;
            end else if ({axi.ARADDR_M, axi.ARLEN_M, axi.ARSIZE_M, axi.ARBURST_M, axi.ARID_M} !==
                         {obs_araddr, obs_arlen, obs_arsize, obs_arburst, obs_arid}) begin
               obs_ar_unstable = 1'b1;
            end
            axi.ARREADY_M = (ar_waited >= ar_wait);
            ar_waited++;
            if (axi.ARREADY_M) obs_ar_hs++;
         end else begin
            axi.ARREADY_M = 1'($urandom_range(0, 1));
         end
         if (axi.RREADY_M) begin
            in_data = 1'b1;
            if (beat < nbeats && (!r_gap || give)) begin
               axi.RVALID_M = 1'b1;
               axi.RDATA_M  = beat_data[beat];
               axi.RRESP_M  = (beat == err_beat) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
               axi.RLAST_M  = (beat == nbeats - 1);
               axi.RID_M    = 4'($urandom);
               beat++;
            end else begin
               axi.RVALID_M = 1'b0; axi.RDATA_M = $urandom; axi.RLAST_M = 1'($urandom);
            end
            give = !give;
         end else begin
            if (in_data && beat < nbeats) obs_rready_drop = 1'b1;
            axi.RVALID_M = 1'b0; axi.RLAST_M = 1'b0;
         end
         @(posedge clk); edges++;
      end
      axi.RVALID_M = 1'b0; axi.ARREADY_M = 1'b0; axi.RLAST_M = 1'b0;
      if (!done) begin
         obs_timeout = 1'b1;
         req_valid = 1'b0; rst = 1'b0;
         @(negedge clk); rst = 1'b1;
         clear_model();
         return;
      end
      obs_lat = edges; obs_line = line_data; obs_err = line_err;
      for (int h = 0; h < ready_hold; h++) begin
         line_ready = 1'b0;
         @(posedge clk); @(negedge clk);
         if (line_valid !== 1'b1 || line_data !== obs_line || line_err !== obs_err || req_ready !== 1'b0)
            obs_hold_unstable = 1'b1;
      end
      req_valid = 1'b0; line_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      obs_rr_after = req_ready; obs_lv_after = line_valid; line_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      tests_run++; if (axi.ARVALID_M !== 1'b0) begin tests_failed++; $display("FAIL reset_arvalid got=%b exp=0", axi.ARVALID_M); end
      tests_run++; if (axi.RREADY_M !== 1'b0) begin tests_failed++; $display("FAIL reset_rready got=%b exp=0", axi.RREADY_M); end
      tests_run++; if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_line_valid got=%b exp=0", line_valid); end
      tests_run++; if (line_err !== 1'b0) begin tests_failed++; $display("FAIL reset_line_err got=%b exp=0", line_err); end
      tests_run++; if (line_data !== '0) begin tests_failed++; $display("FAIL reset_line_data got=%h exp=0", line_data); end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [MAX_BEATS*DATA_W-1:0] lit;
      do_burst(32'h0000_1008, 4'd3, 4, -1, 0, 1'b0, 0, 1'b0);
      lit = {beat_data[3], beat_data[2], beat_data[1], beat_data[0]};
      tests_run++; if (obs_timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout got=%b exp=0", obs_timeout); end
      tests_run++; if (obs_rr_before !== 1'b1) begin tests_failed++; $display("FAIL basic_req_ready got=%b exp=1", obs_rr_before); end
      tests_run++; if (obs_araddr !== 32'h0000_1008) begin tests_failed++; $display("FAIL basic_araddr got=%h exp=00001008", obs_araddr); end
      tests_run++; if (obs_arlen !== 4'd3) begin tests_failed++; $display("FAIL basic_arlen got=%0d exp=3", obs_arlen); end
      tests_run++; if (obs_arsize !== 3'd2) begin tests_failed++; $display("FAIL basic_arsize got=%0d exp=2", obs_arsize); end
      tests_run++; if (obs_arburst !== 2'b01) begin tests_failed++; $display("FAIL basic_arburst got=%0d exp=1", obs_arburst); end
      tests_run++; if (obs_arid !== 4'd0) begin tests_failed++; $display("FAIL basic_arid got=%0d exp=0", obs_arid); end
      tests_run++; if (obs_ar_hs !== 1) begin tests_failed++; $display("FAIL basic_ar_hs got=%0d exp=1", obs_ar_hs); end
      tests_run++; if (obs_lat !== 6) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=6", obs_lat); end
      tests_run++; if (obs_line !== lit) begin tests_failed++; $display("FAIL basic_line got=%h exp=%h", obs_line, lit); end
      tests_run++; if (obs_err !== 1'b0) begin tests_failed++; $display("FAIL basic_err got=%b exp=0", obs_err); end
      tests_run++; if (obs_rr_after !== 1'b1 || obs_lv_after !== 1'b0) begin tests_failed++; $display("FAIL basic_release got=%b%b exp=10", obs_rr_after, obs_lv_after); end
   endtask

   task automatic test_ar_wait();
      logic [3:0] len;
      len = 4'($urandom_range(0, 3));
      do_burst($urandom, len, int'(len) + 1, -1, 5, 1'b0, 0, 1'b0);
      tests_run++; if (obs_ar_unstable !== 1'b0) begin tests_failed++; $display("FAIL arwait_stable got=%b exp=0", obs_ar_unstable); end
      tests_run++; if (obs_ar_hs !== 1) begin tests_failed++; $display("FAIL arwait_ar_hs got=%0d exp=1", obs_ar_hs); end
      tests_run++; if (obs_araddr !== exp_araddr) begin tests_failed++; $display("FAIL arwait_araddr got=%h exp=%h", obs_araddr, exp_araddr); end
      tests_run++; if (obs_lat !== 8 + int'(len)) begin tests_failed++; $display("FAIL arwait_latency got=%0d exp=%0d", obs_lat, 8 + int'(len)); end
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL arwait_line got=%h exp=%h", obs_line, exp_line); end
   endtask

   task automatic test_rvalid_gap();
      do_burst($urandom, 4'd3, 4, -1, 0, 1'b1, 0, 1'b0);
      tests_run++; if (obs_rready_drop !== 1'b0) begin tests_failed++; $display("FAIL gap_rready_drop got=%b exp=0", obs_rready_drop); end
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL gap_line got=%h exp=%h", obs_line, exp_line); end
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL gap_err got=%b exp=%b", obs_err, exp_err); end
   endtask

   task automatic test_errors();
      do_burst($urandom, 4'd3, 4, 2, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL err_rresp got=%b exp=%b", obs_err, exp_err); end
      do_burst($urandom, 4'd3, 2, -1, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_timeout !== 1'b0) begin tests_failed++; $display("FAIL err_early_done got=%b exp=0", obs_timeout); end
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL err_early_last got=%b exp=%b", obs_err, exp_err); end
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL err_early_line got=%h exp=%h", obs_line, exp_line); end
      do_burst($urandom, 4'd1, 2, -1, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL err_cleared got=%b exp=%b", obs_err, exp_err); end
   endtask

   task automatic test_overflow();
      do_burst($urandom, 4'd3, 6, -1, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL ovf_line got=%h exp=%h", obs_line, exp_line); end
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL ovf_err got=%b exp=%b", obs_err, exp_err); end
      do_burst($urandom, 4'd12, 4, -1, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_arlen !== exp_arlen) begin tests_failed++; $display("FAIL clamp_arlen got=%0d exp=%0d", obs_arlen, exp_arlen); end
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL clamp_err got=%b exp=%b", obs_err, exp_err); end
      do_burst($urandom, 4'd0, 1, -1, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_lat !== 3) begin tests_failed++; $display("FAIL single_latency got=%0d exp=3", obs_lat); end
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL single_line got=%h exp=%h", obs_line, exp_line); end
   endtask

   task automatic test_hold();
      do_burst($urandom, 4'd3, 4, -1, 0, 1'b0, 10, 1'b1);
      tests_run++; if (obs_hold_unstable !== 1'b0) begin tests_failed++; $display("FAIL hold_stable got=%b exp=0", obs_hold_unstable); end
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL hold_line got=%h exp=%h", obs_line, exp_line); end
      tests_run++; if (obs_rr_after !== 1'b1) begin tests_failed++; $display("FAIL hold_req_ready_after got=%b exp=1", obs_rr_after); end
      tests_run++; if (obs_lv_after !== 1'b0) begin tests_failed++; $display("FAIL hold_line_valid_after got=%b exp=0", obs_lv_after); end
   endtask

   task automatic test_mid_reset();
      bit resumed = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = $urandom; req_len = 4'd3;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; axi.ARREADY_M = 1'b1;
      @(posedge clk); @(negedge clk);
      axi.ARREADY_M = 1'b0;
      for (int b = 0; b < 2; b++) begin
         axi.RVALID_M = 1'b1; axi.RDATA_M = $urandom; axi.RRESP_M = 2'b00; axi.RLAST_M = 1'b0;
         @(posedge clk); @(negedge clk);
      end
      axi.RDATA_M = $urandom;
      #2 rst = 1'b0;
      #1;
      tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready); end
      tests_run++; if (axi.ARVALID_M !== 1'b0) begin tests_failed++; $display("FAIL midrst_arvalid got=%b exp=0", axi.ARVALID_M); end
      tests_run++; if (axi.RREADY_M !== 1'b0) begin tests_failed++; $display("FAIL midrst_rready got=%b exp=0", axi.RREADY_M); end
      tests_run++; if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_line_valid got=%b exp=0", line_valid); end
      tests_run++; if (line_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_line_err got=%b exp=0", line_err); end
      tests_run++; if (line_data !== '0) begin tests_failed++; $display("FAIL midrst_line_data got=%h exp=0", line_data); end
      @(posedge clk); @(negedge clk);
      axi.RVALID_M = 1'b0; rst = 1'b1;
      clear_model();
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         if (axi.RREADY_M !== 1'b0 || axi.ARVALID_M !== 1'b0) resumed = 1'b1;
      end
      tests_run++; if (resumed !== 1'b0) begin tests_failed++; $display("FAIL midrst_resumed got=%b exp=0", resumed); end
      do_burst($urandom, 4'd1, 2, -1, 0, 1'b0, 0, 1'b0);
      tests_run++; if (obs_timeout !== 1'b0) begin tests_failed++; $display("FAIL midrst_new_timeout got=%b exp=0", obs_timeout); end
      tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL midrst_new_line got=%h exp=%h", obs_line, exp_line); end
      tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL midrst_new_err got=%b exp=%b", obs_err, exp_err); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         logic [3:0] len;
         int clen, nbeats, err_beat;
         len      = 4'($urandom_range(0, 15));
         clen     = (int'(len) > MAX_BEATS - 1) ? MAX_BEATS - 1 : int'(len);
         nbeats   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : clen + 1;
         err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nbeats - 1)) : -1;
         do_burst($urandom, len, nbeats, err_beat, int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         tests_run++; if (obs_timeout !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d_timeout got=%b exp=0", i, obs_timeout); end
         tests_run++; if (obs_araddr !== exp_araddr) begin tests_failed++; $display("FAIL rnd%0d_araddr got=%h exp=%h", i, obs_araddr, exp_araddr); end
         tests_run++; if (obs_arlen !== exp_arlen) begin tests_failed++; $display("FAIL rnd%0d_arlen got=%0d exp=%0d", i, obs_arlen, exp_arlen); end
         tests_run++; if (obs_ar_hs !== 1) begin tests_failed++; $display("FAIL rnd%0d_ar_hs got=%0d exp=1", i, obs_ar_hs); end
         tests_run++; if (obs_line !== exp_line) begin tests_failed++; $display("FAIL rnd%0d_line got=%h exp=%h", i, obs_line, exp_line); end
         tests_run++; if (obs_err !== exp_err) begin tests_failed++; $display("FAIL rnd%0d_err got=%b exp=%b", i, obs_err, exp_err); end
         tests_run++; if (obs_rr_after !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d_req_ready_after got=%b exp=1", i, obs_rr_after); end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_addr = '0; req_len = '0; line_ready = 1'b0;
      axi.ARREADY_M = 1'b0; axi.RVALID_M = 1'b0; axi.RDATA_M = '0;
      axi.RRESP_M = 2'b00; axi.RLAST_M = 1'b0; axi.RID_M = 4'd0;
      clear_model();
      test_reset();
      test_basic();
      test_ar_wait();
      test_rvalid_gap();
      test_errors();
      test_overflow();
      test_hold();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/axi_burst_read_master.md
AXI_BURST_READ_MASTER -- requirements
Module: axi_burst_read_master

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, AXI data width; legal values 32 or 64.
REQ-003 SHALL have parameter MAX_BEATS, 4, maximum beats per burst (power of two, 1..16).
REQ-004 SHALL have parameter ID_VAL, 4'd0, constant driven on ARID_M.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Port clk  in  1  clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid  in  1  refill request.
REQ-008 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-009 SHALL have port req_addr  in  ADDR_W  start byte address.
REQ-010 SHALL have port req_len  in  4  beats minus one; values >= MAX_BEATS are clamped to MAX_BEATS-1.
REQ-011 SHALL have port line_valid  out  1  assembled line available.
REQ-012 SHALL have port line_ready  in  1  consumer takes line.
REQ-013 SHALL have port line_data  out  MAX_BEATS*DATA_W  beat k in bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port line_err  out  1  error status of the delivered line.
REQ-015 SHALL have AXI read-address ports: ARID_M 4, ARADDR_M ADDR_W, ARLEN_M 4, ARSIZE_M 3, ARBURST_M 2 (outputs); ARVALID_M out 1; ARREADY_M in 1.
REQ-016 SHALL have AXI read-data ports: RID_M 4, RDATA_M DATA_W, RRESP_M 2, RLAST_M 1, RVALID_M 1 (inputs); RREADY_M out 1.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> DONE -> IDLE.
REQ-018 SHALL assert req_ready only in IDLE; acceptance latches address and clamped length, clears the beat counter and error, and enters ADDR the next cycle.
REQ-019 SHALL drive ARVALID_M=1 only in ADDR, with ARADDR_M = latched address aligned down to DATA_W/8 bytes, ARLEN_M = latched length, ARSIZE_M = log2(DATA_W/8), ARBURST_M = 2'b01 (INCR), and ARID_M = ID_VAL.
REQ-020 SHALL hold all AR signals stable while ARVALID_M=1 && ARREADY_M=0, and on the handshake enter DATA.
REQ-021 SHALL drive RREADY_M=1 only in DATA; each RVALID_M&&RREADY_M beat SHALL write RDATA_M into line slot beat_cnt and increment beat_cnt.
REQ-022 SHALL saturate beat_cnt at MAX_BEATS-1; extra beats SHALL be accepted, not stored, and flagged per REQ-031.
REQ-023 SHALL leave DATA only on a beat with RLAST_M=1, entering DONE the next cycle; RID_M SHALL be ignored.
REQ-024 SHALL assert line_valid only in DONE and hold line_data and line_err stable until line_ready=1, then return to IDLE.
REQ-025 SHALL leave unfilled slots of line_data at their previous contents (no clearing).
REQ-026 SHALL have minimum request-to-line_valid latency of 3+len cycles with zero-wait ARREADY_M/RVALID_M.
REQ-027 SHALL ignore req_valid outside IDLE; back-to-back requests SHALL see req_ready one cycle after line_ready.

Reset
REQ-028 SHALL, on rst low, asynchronously enter IDLE with req_ready=1, ARVALID_M=0, RREADY_M=0, line_valid=0, line_err=0, line_data=0, and beat_cnt=0.
REQ-029 SHALL abandon any in-flight burst when reset occurs mid-burst, with no resumption after reset.

Configuration
REQ-030 SHALL gate error reporting with macro AXI_RRESP_CHECK_EN.
REQ-031 SHALL, with AXI_RRESP_CHECK_EN defined, set line_err if any beat has RRESP_M[1]=1, if RLAST_M arrives before beat len, or if a beat arrives after beat len without RLAST_M.
REQ-032 SHALL, without AXI_RRESP_CHECK_EN, tie line_err to 0 and omit the check logic.

Verification
REQ-033 SHALL verify: req_addr=0x1008, len=3, DATA_W=32, zero-wait slave -> ARADDR=0x1008, ARLEN=3, ARSIZE=2, ARBURST=1; line_data = {D3,D2,D1,D0}; line_valid at cycle 6.
REQ-034 SHALL verify: ARREADY_M held low for 5 cycles -> AR signals stable throughout; single handshake.
REQ-035 SHALL verify: RVALID_M toggled every other cycle, len=3 -> 4 beats stored in order, and RREADY_M stays high in DATA.
REQ-036 SHALL verify, with macro: beat 2 RRESP=2'b10 -> line_err=1; RLAST on beat 1 with len=3 -> line_err=1 and DONE reached. Without macro -> line_err=0.
REQ-037 SHALL verify: rst low during beat 2 -> next cycle IDLE with all outputs at reset values; new request completes normally.
REQ-038 SHALL verify: line_ready held low 10 cycles -> line_valid and line_data stable and req_ready=0 until release.
